riscv_lsu: RTL and testbench
============================

# riscv_lsu

Multi-cycle load/store unit between the RISC-V core's execute stage and the data memory. It accepts one load or store request at a time and handles the RV32I width and sign rules (SB/SH/SW, LB/LH/LW/LBU/LHU). It drives a word-addressed, byte-enabled memory port with variable acknowledge latency and returns aligned, extended load data or error status to the core. It replaces the core's direct combinational data-memory hookup and lets the core stall on `busy`.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles to wait for `mem_ack` before aborting (1..255).

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: the core presents a request.
- `req_ready` out 1: the LSU is idle and accepts a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Valid values:
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU (loads only)
  - 101 = HU (loads only)
- `req_addr` in 32: byte address (rs1 + imm).
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`. Set on misalignment, illegal funct3, or timeout.
- `busy` out 1: high from acceptance until `resp_valid`, inclusive. The core stalls on it.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: byte enables. Bit i = byte lane i (little-endian).
- `mem_addr` out 32: word address. Bits [1:0] are always 00.
- `mem_wdata` out 32: lane-placed store data.
- `mem_ack` in 1: memory completion. Read data is valid in the same cycle.
- `mem_rdata` in 32: word read data.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. When `req_valid` is high, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
    - If the request is illegal or misaligned, go to RESP with the error flag set.
    - Otherwise go to ACCESS and clear the timeout counter.
  - ACCESS: `mem_req`=1, and all `mem_*` outputs are stable.
    - On `mem_ack`: capture `mem_rdata` and go to RESP.
    - If the counter reaches TIMEOUT without an ack: drop the request, set the error flag, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Illegal funct3: 011, 110, 111, and 100 or 101 with `req_we`=1.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- Store lane placement, with off = addr[1:0]:
  - SB: byte replicated to all 4 lanes, `mem_be` = 0001<<off.
  - SH: halfword replicated to both halves, `mem_be` = 0011<<off.
  - SW: `mem_wdata` = wdata, `mem_be` = 1111.
- Load extraction: shift the captured word right by 8*off.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - Loads drive `mem_be` = 1111 and `mem_we`=0.
- `mem_addr` = {addr[31:2], 2'b00}.
- `mem_ack` is ignored outside ACCESS.
- Only one request is in flight. While `req_ready`=0, `req_valid` and the request fields are ignored.

## Timing
- Reset, sampled at an edge, puts the FSM in IDLE and clears the counter.
- In the following cycle all outputs are 0 except `req_ready`=1.
- Reset mid-ACCESS drops `mem_req` after that same edge. No response is produced for the aborted request.
- Request accepted at edge T:
  - `busy`=1 and `mem_req`=1 from cycle T+1.
  - `mem_ack` sampled high at edge A → `resp_valid` during cycle A+1.
  - `req_ready`=1 in cycle A+2.
- Minimum legal access: ack in the first ACCESS cycle, giving 3 cycles from acceptance edge to ready again.
- Error path: `resp_valid`/`resp_err` in cycle T+1, with no `mem_req` at any time.
- Timeout:
  - The counter increments on each ACCESS cycle without ack.
  - At count == TIMEOUT: `mem_req` falls and `resp_valid`+`resp_err` follow in the next cycle.
  - An ack in the same cycle the counter hits TIMEOUT wins: normal completion.
- Back-to-back: a new request may be accepted in the first IDLE cycle after RESP.
- Responses are registered. `resp_*` outputs never combinationally depend on `mem_ack`/`mem_rdata`.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset` 2 cycles, then release.
  - Required: `req_ready`=1, `mem_req`=0, `resp_valid`=0, `busy`=0.
  - `mem_ack` pulses in IDLE cause no response.
- SB:
  - Stimulus: addr=0x0000_0103, wdata=0x1234_56AB, ack after 2 wait cycles.
  - Required: `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0xABAB_ABAB, `mem_we`=1.
  - `resp_valid` appears 1 cycle after the ack, with `resp_err`=0.
- Loads from addr=0x0000_0202 with `mem_rdata`=0x80F1_7F00:
  - LB → 0xFFFF_FFF1.
  - LBU → 0x0000_00F1.
  - LH → 0xFFFF_80F1.
  - LHU → 0x0000_80F1.
  - LW at 0x200 → 0x80F1_7F00.
- Errors, each giving `resp_valid`+`resp_err` in T+1 and no `mem_req`:
  - LW at 0x202.
  - SH at 0x001.
  - Store with funct3=100.
  - funct3=111.
- Timeout (TIMEOUT=4): never ack.
  - Required: `mem_req` high 4 cycles, then `resp_err`=1, `resp_rdata`=0.
  - Second case: an ack exactly on the 4th cycle → normal completion, `resp_err`=0.
- Reset mid-access: assert `reset` during ACCESS.
  - Required: `mem_req`=0 next cycle, no `resp_valid`.
  - A following LW completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one request at a time, byte-enabled word memory port,
// registered response with sign/zero extension, misalignment and timeout errors.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx;
  logic        err_q, err_nx;
  logic [7:0]  cnt_q, cnt_nx, cnt_inc;
  logic        req_illegal, req_misal, accept;
  logic [31:0] shifted, load_data, st_data;
  logic [3:0]  st_be;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so fields are ignored at all other times.
  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_we;
      default:                req_illegal = 1'b1;
    endcase
    req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = shifted;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Sub-word stores replicate the data so every enabled lane already holds it.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    err_nx   = err_q;
    rdata_nx = rdata_q;
    cnt_inc  = cnt_q + 8'd1;
    case (state)
      S_IDLE: begin
        err_nx   = 1'b0;
        rdata_nx = 32'd0;
        if (req_valid) begin
          cnt_nx = 8'd0;
          if (req_illegal || req_misal) begin
            err_nx   = 1'b1;
            state_nx = S_RESP;
          end else begin
            state_nx = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_nx = S_RESP;
          err_nx   = 1'b0;
          rdata_nx = we_q ? 32'd0 : load_data;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            state_nx = S_RESP;
            err_nx   = 1'b1;
            rdata_nx = 32'd0;
          end
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
      rdata_q <= rdata_nx;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign mem_req    = (state == S_ACCESS);
  assign mem_we     = mem_req & we_q;
  assign mem_be     = mem_req ? (we_q ? st_be : 4'b1111) : 4'b0000;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = (mem_req && we_q) ? st_data : 32'd0;
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases plus random traffic, with a
// queue-based scoreboard checked by an independent response monitor.
module tb_riscv_lsu;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  dbg_state;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [32:0] e;
    if (!reset && resp_valid) begin
      check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(e[32]));
        check("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          access;
    bit          err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd, input bit to);
    exp_t   e;
    int     n, off;
    longint v;
    e = '{default: 0};
    off = int'(addr[1:0]);
    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 0;
    endcase
    if (n == 0) begin
      e.err = 1;
      return e;
    end
    if ((f3[2] && (we || n == 4)) || (off % n) != 0) begin
      e.err = 1;
      return e;
    end
    e.access = 1;
    e.err    = to;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        e.be[i] = (i >= off) && (i < off + n);
      end
    end else begin
      e.be = 4'hF;
      if (!to) begin
        v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
          v = v - (longint'(1) << (8 * n));
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called with the LSU idle; returns at the falling edge of the first idle cycle
  // after the response, so consecutive calls exercise back-to-back acceptance.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_cyc, input logic [31:0] rd);
    exp_t e;
    int   c;
    bit   acked;
    e = model(we, f3, addr, wd, rd, wait_cyc >= TO);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock);
    #1;
    exp_q.push_back({e.err, e.rdata});
    // junk on the request port while busy must be ignored
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (e.access) begin
      c = 0;
      acked = 0;
      while (!acked && c < TO) begin
        c++;
        if (c == wait_cyc + 1) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
          acked = 1;
        end
        @(negedge clock);
        check("mem_req", 32'(mem_req), 32'd1);
        check("busy_access", 32'(busy), 32'd1);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_we", 32'(mem_we), 32'(we));
        check("mem_be", 32'(mem_be), 32'(e.be));
        if (we) check("mem_wdata", mem_wdata, e.wdata);
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    @(negedge clock);
    check("resp_valid_latency", 32'(resp_valid), 32'd1);
    check("mem_req_in_resp", 32'(mem_req), 32'd0);
    check("busy_in_resp", 32'(busy), 32'd1);
    req_valid = 1'b0;
    @(negedge clock);
    check("ready_after_resp", 32'(req_ready), 32'd1);
    check("resp_single_pulse", 32'(resp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] idle_code;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    idle_code = dbg_state;

    // stray acks while idle
    repeat (3) begin
      @(posedge clock);
      #1 mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(negedge clock);
      check("idle_ack_no_resp", 32'(resp_valid), 32'd0);
      check("idle_ack_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clock);
    #1 mem_ack = 1'b0;

    // SB lane placement
    do_req(1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 2, $urandom);
    // loads with sign / zero extension
    do_req(1'b0, 3'b000, 32'h0000_0202, $urandom, 1, 32'h80F1_7F00);
    do_req(1'b0, 3'b100, 32'h0000_0202, $urandom, 0, 32'h80F1_7F00);
    do_req(1'b0, 3'b001, 32'h0000_0202, $urandom, 3, 32'h80F1_7F00);
    do_req(1'b0, 3'b101, 32'h0000_0202, $urandom, 1, 32'h80F1_7F00);
    do_req(1'b0, 3'b010, 32'h0000_0200, $urandom, 0, 32'h80F1_7F00);
    // error path
    do_req(1'b0, 3'b010, 32'h0000_0202, $urandom, 0, $urandom);
    do_req(1'b1, 3'b001, 32'h0000_0001, $urandom, 0, $urandom);
    do_req(1'b1, 3'b100, 32'h0000_0010, $urandom, 0, $urandom);
    do_req(1'b0, 3'b111, 32'h0000_0020, $urandom, 0, $urandom);
    // timeout, then ack on the last allowed cycle
    do_req(1'b0, 3'b010, 32'h0000_0300, $urandom, 20, $urandom);
    do_req(1'b0, 3'b010, 32'h0000_0304, $urandom, TO - 1, 32'hCAFE_F00D);
    do_req(1'b1, 3'b010, 32'h0000_0308, 32'h0BAD_BEEF, TO - 1, $urandom);

    // reset during an access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("mid_mem_req", 32'(mem_req), 32'd1);
    check("mid_dbg_state_not_idle", 32'(dbg_state != idle_code), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("abort_no_late_resp", 32'(resp_valid), 32'd0);
    do_req(1'b0, 3'b010, 32'h0000_0500, $urandom, 1, 32'h1357_9BDF);

    // random traffic
    repeat (200) begin
      logic [31:0] a;
      a = $urandom;
      a[1:0] = 2'($urandom_range(0, 3));
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, TO + 1), $urandom);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
